// File: rtl/game_match_ctrl.sv
// Best-of-N match sequencer for the two-player Game datapath: round timing,
// command gating, KO/timeout detection and match scoring.
//
// state      | meaning
// IDLE       | waiting for START, Game held in reset
// ROUND_INIT | one cycle, Game in reset, turn timer loaded
// COUNTDOWN  | Game running with idle commands
// FIGHT      | live play, one-hot commands pass, outcome checked each cycle
// ROUND_END  | hold with final HP visible
// MATCH_END  | winner reported, waiting for START
module game_match_ctrl #(
  parameter int TURN_LIMIT    = 16,
  parameter int COUNTDOWN_CYC = 3,
  parameter int END_CYC       = 4,
  parameter int WINS_NEEDED   = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] P1_IN,
  input  logic [5:0] P2_IN,
  input  logic [1:0] HP1,
  input  logic [1:0] HP2,
  output logic [5:0] P1,
  output logic [5:0] P2,
  output logic       GAME_RST,
  output logic [2:0] ROUND,
  output logic [4:0] TIMER,
  output logic [1:0] WINS1,
  output logic [1:0] WINS2,
  output logic       MATCH_OVER,
  output logic [1:0] WINNER,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ROUND_INIT = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_FIGHT      = 3'd3,
    S_ROUND_END  = 3'd4,
    S_MATCH_END  = 3'd5
  } state_t;

  localparam logic [4:0] TIMER_LOAD = 5'(TURN_LIMIT);
  localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_CYC - 1);
  localparam logic [7:0] END_LOAD   = 8'(END_CYC - 1);
  localparam logic [1:0] WINS_GOAL  = 2'(WINS_NEEDED);
  localparam logic [2:0] ROUND_LAST = 3'(MAX_ROUNDS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] p1_q, p1_d, p2_q, p2_d;
  logic       game_rst_q, game_rst_d;
  logic [2:0] round_q, round_d;
  logic [4:0] timer_q, timer_d;
  logic [1:0] wins1_q, wins1_d, wins2_q, wins2_d;
  logic       match_over_q, match_over_d;
  logic [1:0] winner_q, winner_d;

  function automatic logic [5:0] gate_cmd(input logic [5:0] cmd);
    return $onehot(cmd) ? cmd : 6'd0;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      game_rst_q   <= 1'b1;
      round_q      <= '0;
      timer_q      <= '0;
      wins1_q      <= '0;
      wins2_q      <= '0;
      match_over_q <= 1'b0;
      winner_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      game_rst_q   <= game_rst_d;
      round_q      <= round_d;
      timer_q      <= timer_d;
      wins1_q      <= wins1_d;
      wins2_q      <= wins2_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
    end
  end

  // Every output is computed for the state being entered, so the registered
  // values line up with STATE on the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p1_d         = 6'd0;
    p2_d         = 6'd0;
    game_rst_d   = game_rst_q;
    round_d      = round_q;
    timer_d      = timer_q;
    wins1_d      = wins1_q;
    wins2_d      = wins2_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;

    case (state_q)
      S_IDLE, S_MATCH_END: begin
        if (START) begin
          state_d      = S_ROUND_INIT;
          round_d      = 3'd1;
          wins1_d      = 2'd0;
          wins2_d      = 2'd0;
          winner_d     = 2'd0;
          match_over_d = 1'b0;
          game_rst_d   = 1'b1;
          timer_d      = TIMER_LOAD;
        end
      end
      S_ROUND_INIT: begin
        state_d    = S_COUNTDOWN;
        game_rst_d = 1'b0;
        cnt_d      = CD_LOAD;
      end
      S_COUNTDOWN: begin
        if (cnt_q == 8'd0) state_d = S_FIGHT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_FIGHT: begin
        p1_d    = gate_cmd(P1_IN);
        p2_d    = gate_cmd(P2_IN);
        timer_d = timer_q - 5'd1;
        if (HP1 == 2'd0 || HP2 == 2'd0 || timer_q == 5'd1) begin
          state_d = S_ROUND_END;
          cnt_d   = END_LOAD;
          p1_d    = 6'd0;
          p2_d    = 6'd0;
          if (HP1 == 2'd0 && HP2 == 2'd0) begin
            // double KO is a draw
          end else if (HP2 == 2'd0) begin
            wins1_d = wins1_q + 2'd1;
          end else if (HP1 == 2'd0) begin
            wins2_d = wins2_q + 2'd1;
          end else if (HP1 > HP2) begin
            wins1_d = wins1_q + 2'd1;
          end else if (HP2 > HP1) begin
            wins2_d = wins2_q + 2'd1;
          end
        end
      end
      S_ROUND_END: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (wins1_q == WINS_GOAL || wins2_q == WINS_GOAL ||
                     round_q == ROUND_LAST) begin
          state_d      = S_MATCH_END;
          match_over_d = 1'b1;
          game_rst_d   = 1'b1;
          if (wins1_q > wins2_q)      winner_d = 2'b01;
          else if (wins1_q < wins2_q) winner_d = 2'b10;
          else                        winner_d = 2'b11;
        end else begin
          state_d    = S_ROUND_INIT;
          round_d    = round_q + 3'd1;
          game_rst_d = 1'b1;
          timer_d    = TIMER_LOAD;
        end
      end
      default: begin
        state_d    = S_IDLE;
        game_rst_d = 1'b1;
      end
    endcase
  end

  assign P1         = p1_q;
  assign P2         = p2_q;
  assign GAME_RST   = game_rst_q;
  assign ROUND      = round_q;
  assign TIMER      = timer_q;
  assign WINS1      = wins1_q;
  assign WINS2      = wins2_q;
  assign MATCH_OVER = match_over_q;
  assign WINNER     = winner_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_game_match_ctrl.sv
// Directed bench for game_match_ctrl with default parameters; expected values
// are hand-computed cycle counts and scores.
module tb_game_match_ctrl;
  logic       CLK = 1'b0;
  logic       RST, START;
  logic [5:0] P1_IN, P2_IN;
  logic [1:0] HP1, HP2;
  logic [5:0] P1, P2;
  logic       GAME_RST;
  logic [2:0] ROUND;
  logic [4:0] TIMER;
  logic [1:0] WINS1, WINS2;
  logic       MATCH_OVER;
  logic [1:0] WINNER;
  logic [2:0] STATE;

  int checks   = 0;
  int failures = 0;

  game_match_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .P1_IN(P1_IN), .P2_IN(P2_IN),
    .HP1(HP1), .HP2(HP2), .P1(P1), .P2(P2), .GAME_RST(GAME_RST),
    .ROUND(ROUND), .TIMER(TIMER), .WINS1(WINS1), .WINS2(WINS2),
    .MATCH_OVER(MATCH_OVER), .WINNER(WINNER), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_state"}, 32'(STATE), 0);
    chk({pfx, "_grst"}, 32'(GAME_RST), 1);
    chk({pfx, "_p1"}, 32'(P1), 0);
    chk({pfx, "_p2"}, 32'(P2), 0);
    chk({pfx, "_round"}, 32'(ROUND), 0);
    chk({pfx, "_timer"}, 32'(TIMER), 0);
    chk({pfx, "_wins1"}, 32'(WINS1), 0);
    chk({pfx, "_wins2"}, 32'(WINS2), 0);
    chk({pfx, "_mover"}, 32'(MATCH_OVER), 0);
    chk({pfx, "_winner"}, 32'(WINNER), 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; P1_IN = '0; P2_IN = '0; HP1 = 2'd3; HP2 = 2'd3;
    step(2);
    chk_reset("rst");
    RST = 1'b0;
    step(3);
    chk_reset("idle");

    // Match 1: gating, KO win, timeout win -> P1 takes the match 2-0
    START = 1'b1;
    step();
    START = 1'b0;
    P1_IN = 6'b000010;
    chk("init_state", 32'(STATE), 1);
    chk("init_round", 32'(ROUND), 1);
    chk("init_timer", 32'(TIMER), 16);
    chk("init_grst", 32'(GAME_RST), 1);
    step(2);
    chk("cd_state", 32'(STATE), 2);
    chk("cd_grst", 32'(GAME_RST), 0);
    chk("cd_gate_p1", 32'(P1), 0);
    step(2);
    chk("fight_state", 32'(STATE), 3);
    chk("fight_timer_first", 32'(TIMER), 16);
    P1_IN = 6'b010000; P2_IN = 6'b100000;
    step();
    chk("gate_p1_onehot", 32'(P1), 32'h10);
    chk("gate_p2_onehot", 32'(P2), 32'h20);
    chk("fight_timer_dec", 32'(TIMER), 15);
    P1_IN = 6'b010010; P2_IN = 6'b000001;
    step();
    chk("gate_p1_twohot", 32'(P1), 0);
    chk("gate_p2_onehot_b", 32'(P2), 1);
    P1_IN = 6'b000100; P2_IN = 6'b000000; HP2 = 2'd0;
    step();
    chk("ko_state", 32'(STATE), 4);
    chk("ko_wins1", 32'(WINS1), 1);
    chk("ko_wins2", 32'(WINS2), 0);
    chk("ko_p1_zero", 32'(P1), 0);
    chk("ko_grst", 32'(GAME_RST), 0);
    P1_IN = '0; HP2 = 2'd3;
    step(3);
    chk("end_hold_state", 32'(STATE), 4);
    step();
    chk("r2_state", 32'(STATE), 1);
    chk("r2_round", 32'(ROUND), 2);
    chk("r2_timer", 32'(TIMER), 16);
    HP1 = 2'd2; HP2 = 2'd1;
    step(4);
    chk("r2_fight", 32'(STATE), 3);
    step(15);
    chk("r2_last_fight", 32'(STATE), 3);
    chk("r2_timer_last", 32'(TIMER), 1);
    step();
    chk("to_state", 32'(STATE), 4);
    chk("to_wins1", 32'(WINS1), 2);
    step(4);
    chk("m1_state", 32'(STATE), 5);
    chk("m1_mover", 32'(MATCH_OVER), 1);
    chk("m1_winner", 32'(WINNER), 1);
    chk("m1_grst", 32'(GAME_RST), 1);
    step(3);
    chk("m1_winner_held", 32'(WINNER), 1);

    // Match 2: five draws -> WINNER 11
    START = 1'b1;
    step();
    START = 1'b0;
    chk("m2_round", 32'(ROUND), 1);
    chk("m2_wins1", 32'(WINS1), 0);
    chk("m2_winner", 32'(WINNER), 0);
    chk("m2_mover", 32'(MATCH_OVER), 0);
    HP1 = 2'd0; HP2 = 2'd0;
    step(5);
    chk("dko_state", 32'(STATE), 4);
    chk("dko_wins1", 32'(WINS1), 0);
    chk("dko_wins2", 32'(WINS2), 0);
    step(4);
    chk("dko_next_round", 32'(ROUND), 2);
    HP1 = 2'd2; HP2 = 2'd2;
    step(4);
    START = 1'b1;
    step(16);
    START = 1'b0;
    chk("tie_state", 32'(STATE), 4);
    chk("tie_round", 32'(ROUND), 2);
    chk("tie_wins1", 32'(WINS1), 0);
    chk("tie_wins2", 32'(WINS2), 0);
    step(4);
    chk("tie_next_round", 32'(ROUND), 3);
    HP1 = 2'd0; HP2 = 2'd0;
    for (int r = 3; r <= 5; r++) begin
      step(5);
      chk("draw_state", 32'(STATE), 4);
      step(4);
      if (r < 5) chk("draw_round", 32'(ROUND), 32'(r + 1));
    end
    chk("m2_end_state", 32'(STATE), 5);
    chk("m2_end_round", 32'(ROUND), 5);
    chk("m2_end_winner", 32'(WINNER), 3);

    // Match 3: P2 wins two rounds by KO
    START = 1'b1;
    step();
    START = 1'b0;
    chk("m3_round", 32'(ROUND), 1);
    HP1 = 2'd0; HP2 = 2'd3;
    step(5);
    chk("m3_r1_wins2", 32'(WINS2), 1);
    step(9);
    chk("m3_r2_wins2", 32'(WINS2), 2);
    step(4);
    chk("m3_state", 32'(STATE), 5);
    chk("m3_winner", 32'(WINNER), 2);
    chk("m3_mover", 32'(MATCH_OVER), 1);
    chk("m3_grst", 32'(GAME_RST), 1);

    // Match 4: reset in the middle of round 2
    START = 1'b1;
    step();
    START = 1'b0;
    HP1 = 2'd3; HP2 = 2'd0;
    step(5);
    chk("m4_wins1", 32'(WINS1), 1);
    HP2 = 2'd3;
    step(8);
    step(2);
    chk("m4_fight", 32'(STATE), 3);
    RST = 1'b1;
    step();
    chk_reset("midrst");
    RST = 1'b0;
    step(2);
    chk("post_rst_state", 32'(STATE), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("restart_state", 32'(STATE), 1);
    chk("restart_round", 32'(ROUND), 1);
    chk("restart_wins1", 32'(WINS1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_match_ctrl.md
# game_match_ctrl

Match-level controller that sequences the two-player `Game` datapath through a best-of-N match. It sits between the raw player command inputs and `Game`. It holds `Game` in reset between rounds, gates player commands so only one-hot moves reach the datapath during live play, and runs a per-round turn timer. It detects KO and timeout from `HP1`/`HP2`, keeps per-player round-win counts and reports the match winner.

## Interface

- `TURN_LIMIT`, 16: fight cycles per round before timeout (1..31)
- `COUNTDOWN_CYC`, 3: cycles of forced-idle commands after `Game` reset, before fighting (≥1)
- `END_CYC`, 4: hold cycles in ROUND_END (≥1)
- `WINS_NEEDED`, 2: round wins that end the match (1..3)
- `MAX_ROUNDS`, 5: rounds after which the match ends regardless (1..7)

- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `START`  in  1  start-match request; sampled only in IDLE or MATCH_END
- `P1_IN`, `P2_IN`  in  6  raw player commands
- `HP1`, `HP2`  in  2  health returned by `Game`
- `P1`, `P2`  out  6  registered gated commands driven to `Game`
- `GAME_RST`  out  1  reset driven to `Game`
- `ROUND`  out  3  current round number, 1-based
- `TIMER`  out  5  remaining fight cycles
- `WINS1`, `WINS2`  out  2  rounds won per player
- `MATCH_OVER`  out  1  high in MATCH_END
- `WINNER`  out  2  00 none, 01 P1, 10 P2, 11 draw
- `STATE`  out  3  IDLE=0, ROUND_INIT=1, COUNTDOWN=2, FIGHT=3, ROUND_END=4, MATCH_END=5

## Operation

- **IDLE:** `GAME_RST`=1, `P1`/`P2`=0. `START` → ROUND_INIT. On that transition: `ROUND`=1, `WINS1`=`WINS2`=0, `WINNER`=00.
- **ROUND_INIT** (1 cycle): `GAME_RST`=1, `TIMER` loaded with `TURN_LIMIT`. Next state COUNTDOWN.
- **COUNTDOWN** (`COUNTDOWN_CYC` cycles): `GAME_RST`=0, `P1`/`P2` forced 0. Next state FIGHT.
- **FIGHT:**
  - Each cycle, `P1` <= `P1_IN` if it has exactly one bit set, else 000000. Same rule for `P2`.
  - `TIMER` decrements by 1 per cycle.
  - Outcome is evaluated every cycle on the current `HP1`/`HP2`. KO has priority over timeout in the same cycle.
  - Both HP=0: draw, no win credited.
  - `HP2`=0 only: `WINS1`++.
  - `HP1`=0 only: `WINS2`++.
  - Otherwise, if `TIMER`==1: timeout. Higher HP wins (counter ++). Equal HP is a draw.
  - Any outcome → ROUND_END.
- **ROUND_END** (`END_CYC` cycles):
  - `P1`/`P2`=0, `GAME_RST`=0 (final HP stays visible).
  - On exit, if `WINS1`==`WINS_NEEDED`, `WINS2`==`WINS_NEEDED`, or `ROUND`==`MAX_ROUNDS` → MATCH_END.
  - Else `ROUND`++ and → ROUND_INIT.
- **MATCH_END:**
  - `MATCH_OVER`=1, `GAME_RST`=1.
  - `WINNER`: 01 if `WINS1`>`WINS2`, 10 if less, 11 if equal. Held until exit.
  - `START` → ROUND_INIT with counters cleared, same as from IDLE.
- Draws consume a round. Win counters saturate at `WINS_NEEDED` by construction.
- `START` in any other state is ignored.

## Timing

- All outputs are registered.
- **Reset values:** `STATE`=IDLE, `GAME_RST`=1, `P1`=`P2`=0, `ROUND`=0, `TIMER`=0, `WINS1`=`WINS2`=0, `MATCH_OVER`=0, `WINNER`=00.
- `RST` at any cycle, including mid-FIGHT, returns to reset values on the next edge. No partial round is credited.
- Command latency is 1 cycle: `P1_IN` sampled at edge k appears on `P1` after edge k.
- `HP` effects of command k reach the controller no earlier than edge k+2. The outcome is registered at the edge where the KO is sampled; STATE=ROUND_END and the win counter are visible together.
- **Round length without KO:** 1 (INIT) + `COUNTDOWN_CYC` + `TURN_LIMIT` + `END_CYC` cycles.
  - `TIMER` reads `TURN_LIMIT` on the first FIGHT cycle and 1 on the last.
  - `TIMER` holds its value outside FIGHT.
- START→first FIGHT cycle is 1 + 1 + `COUNTDOWN_CYC` edges.

## Test plan

- **Reset/idle:** `RST`=1 for 2 cycles, then `START`=0 → `STATE`=0, `GAME_RST`=1, `P1`=`P2`=0, all counters 0, held indefinitely.
- **Command gating:**
  - `P1_IN`=010000 during FIGHT → `P1`=010000 one cycle later.
  - `P1_IN`=010010 → `P1`=000000.
  - `P1_IN`=000010 during COUNTDOWN → `P1`=000000.
- **KO win:** drive `HP2`=0 in FIGHT with `HP1`=3 → next cycle `STATE`=4, `WINS1`=1. After `END_CYC`=4 cycles, `ROUND`=2 and `STATE`=1.
- **Timeout and tie:**
  - Hold `HP1`=2, `HP2`=1 for a round → after `TURN_LIMIT`=16 FIGHT cycles, `WINS1`++.
  - With `HP1`=`HP2`=2 → draw: no counter change, `ROUND`++.
  - Simultaneous `HP1`=`HP2`=0 → draw.
- **Match end:**
  - P2 wins rounds 1 and 2 → `MATCH_OVER`=1, `WINNER`=10, `GAME_RST`=1.
  - 5 consecutive draws → `WINNER`=11 after round 5.
  - `START` from there restarts with `ROUND`=1 and wins cleared.
- **Reset mid-fight:** `RST` pulse during FIGHT with `WINS1`=1 → all outputs at reset values next cycle. A later `START` begins at `ROUND`=1.
